// File: rtl/sonic_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : sonic_scan_sched
// Brief    : Round-robin / single-shot scheduler for NUM_CH ultrasonic ranging
//            channels with a guard gap between shots and a result table.
//            Optional shot timeout enabled by macro SONIC_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sonic_scan_sched #(
    parameter int NUM_CH         = 4,
    parameter int GAP_CYCLES     = 20000
`ifdef SONIC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 3000000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_en_i,
    input  logic                  trig_i,
    input  logic [NUM_CH-1:0]     ch_mask_i,
    output logic [NUM_CH-1:0]     sens_req_o,
    input  logic [NUM_CH-1:0]     sens_busy_i,
    input  logic [NUM_CH-1:0]     sens_finish_i,
    input  logic [NUM_CH*32-1:0]  sens_data_i,
    output logic                  res_valid_o,
    output logic [3:0]            res_ch_o,
    output logic [31:0]           res_data_o,
    output logic                  round_done_o,
    input  logic [3:0]            rd_sel_i,
    output logic [31:0]           rd_data_o,
    output logic                  active_o
`ifdef SONIC_SCHED_TIMEOUT_EN
    ,
    output logic [NUM_CH-1:0]     err_flags_o
`endif
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`ifdef SONIC_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_STORE     = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           ch_q, ch_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [31:0]          cap_q, cap_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_CH-1:0]    req_q, req_d;
    logic                 res_valid_q, res_valid_d;
    logic [3:0]           res_ch_q, res_ch_d;
    logic [31:0]          res_data_q, res_data_d;
    logic                 round_done_q, round_done_d;
    logic [31:0]          tbl_q [NUM_CH];
    logic [31:0]          tbl_d [NUM_CH];
    logic [31:0]          rd_data_q, rd_data_d;
`ifdef SONIC_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]      to_q, to_d;
    logic [NUM_CH-1:0]    err_q, err_d;
`endif

    // Channel selection helpers: decoded pointer, muxed sensor inputs,
    // next enabled channel above the pointer, and lowest channel of a fresh mask.
    logic [NUM_CH-1:0]    sel_oh;
    logic                 sel_busy;
    logic                 sel_finish;
    logic [31:0]          sel_data;
    logic                 next_found;
    logic [3:0]           next_ch;
    logic [3:0]           first_ch;

    always_comb begin
        sel_oh     = '0;
        sel_data   = '0;
        next_found = 1'b0;
        next_ch    = '0;
        first_ch   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == 4'(k)) begin
                sel_oh[k] = 1'b1;
                sel_data  = sens_data_i[32*k +: 32];
            end
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_q[k] && (4'(k) > ch_q)) begin
                next_found = 1'b1;
                next_ch    = 4'(k);
            end
            if (ch_mask_i[k]) begin
                first_ch = 4'(k);
            end
        end
        sel_busy   = |(sens_busy_i & sel_oh);
        sel_finish = |(sens_finish_i & sel_oh);
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        mask_d       = mask_q;
        cap_d        = cap_q;
        gap_d        = gap_q;
        req_d        = '0;
        res_valid_d  = 1'b0;
        res_ch_d     = res_ch_q;
        res_data_d   = res_data_q;
        round_done_d = 1'b0;
        tbl_d        = tbl_q;
`ifdef SONIC_SCHED_TIMEOUT_EN
        to_d         = to_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((scan_en_i || trig_i) && (|ch_mask_i)) begin
                    mask_d  = ch_mask_i;
                    ch_d    = first_ch;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!sel_busy) begin
                    req_d   = sel_oh;
                    state_d = S_WAIT_DONE;
`ifdef SONIC_SCHED_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (sel_finish) begin
                    cap_d   = sel_data;
                    state_d = S_STORE;
                end
`ifdef SONIC_SCHED_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    cap_d   = 32'hFFFF_FFFF;
                    err_d   = err_q | sel_oh;
                    state_d = S_STORE;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            S_STORE: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (sel_oh[k]) begin
                        tbl_d[k] = cap_q;
                    end
                end
                res_valid_d = 1'b1;
                res_ch_d    = ch_q;
                res_data_d  = cap_q;
                gap_d       = '0;
                state_d     = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (next_found) begin
                        ch_d    = next_ch;
                        state_d = S_ISSUE;
                    end else begin
                        // End of round; scanning wraps onto a freshly sampled mask.
                        round_done_d = 1'b1;
                        if (scan_en_i && (|ch_mask_i)) begin
                            mask_d  = ch_mask_i;
                            ch_d    = first_ch;
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel_i == 4'(k)) begin
                rd_data_d = tbl_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            mask_q       <= '0;
            cap_q        <= '0;
            gap_q        <= '0;
            req_q        <= '0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= '0;
            res_data_q   <= '0;
            round_done_q <= 1'b0;
            rd_data_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                tbl_q[k] <= '0;
            end
`ifdef SONIC_SCHED_TIMEOUT_EN
            to_q         <= '0;
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            mask_q       <= mask_d;
            cap_q        <= cap_d;
            gap_q        <= gap_d;
            req_q        <= req_d;
            res_valid_q  <= res_valid_d;
            res_ch_q     <= res_ch_d;
            res_data_q   <= res_data_d;
            round_done_q <= round_done_d;
            rd_data_q    <= rd_data_d;
            for (int k = 0; k < NUM_CH; k++) begin
                tbl_q[k] <= tbl_d[k];
            end
`ifdef SONIC_SCHED_TIMEOUT_EN
            to_q         <= to_d;
            err_q        <= err_d;
`endif
        end
    end

    assign sens_req_o   = req_q;
    assign res_valid_o  = res_valid_q;
    assign res_ch_o     = res_ch_q;
    assign res_data_o   = res_data_q;
    assign round_done_o = round_done_q;
    assign rd_data_o    = rd_data_q;
    assign active_o     = (state_q != S_IDLE);
`ifdef SONIC_SCHED_TIMEOUT_EN
    assign err_flags_o  = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sonic_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonic_scan_sched
// Brief    : Directed self-checking bench for sonic_scan_sched with a
//            behavioural sensor per channel (busy after req, finish after 50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonic_scan_sched;

    localparam int NCH  = 4;
    localparam int GAP  = 10;
    localparam int TMO  = 200;
    localparam int SLAT = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             scan_en;
    logic             trig;
    logic [NCH-1:0]   ch_mask;
    logic [NCH-1:0]   sens_req;
    logic [NCH-1:0]   sens_busy;
    logic [NCH-1:0]   sens_finish;
    logic [NCH*32-1:0] sens_data;
    logic             res_valid;
    logic [3:0]       res_ch;
    logic [31:0]      res_data;
    logic             round_done;
    logic [3:0]       rd_sel;
    logic [31:0]      rd_data;
    logic             active;
`ifdef SONIC_SCHED_TIMEOUT_EN
    logic [NCH-1:0]   err_flags;
`endif

    logic [NCH-1:0]   busy_force = '0;
    logic [NCH-1:0]   fin_inj    = '0;
    logic [NCH-1:0]   no_fin     = '0;
    logic [NCH-1:0]   m_busy;
    logic [NCH-1:0]   m_fin;
    int               mcnt [NCH] = '{default: 0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sonic_scan_sched #(
        .NUM_CH         (NCH),
        .GAP_CYCLES     (GAP)
`ifdef SONIC_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scan_en_i     (scan_en),
        .trig_i        (trig),
        .ch_mask_i     (ch_mask),
        .sens_req_o    (sens_req),
        .sens_busy_i   (sens_busy),
        .sens_finish_i (sens_finish),
        .sens_data_i   (sens_data),
        .res_valid_o   (res_valid),
        .res_ch_o      (res_ch),
        .res_data_o    (res_data),
        .round_done_o  (round_done),
        .rd_sel_i      (rd_sel),
        .rd_data_o     (rd_data),
        .active_o      (active)
`ifdef SONIC_SCHED_TIMEOUT_EN
        ,
        .err_flags_o   (err_flags)
`endif
    );

    // Behavioural sensors: not reset by rst, so a shot in flight still completes.
    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (mcnt[k] == 0) begin
                if (sens_req[k] === 1'b1) mcnt[k] <= 1;
            end else if (mcnt[k] == SLAT) begin
                mcnt[k] <= 0;
            end else begin
                mcnt[k] <= mcnt[k] + 1;
            end
        end
    end

    always_comb begin
        m_busy    = '0;
        m_fin     = '0;
        sens_data = '0;
        for (int k = 0; k < NCH; k++) begin
            m_busy[k]            = (mcnt[k] != 0);
            m_fin[k]             = (mcnt[k] == SLAT) && !no_fin[k];
            sens_data[32*k +: 32] = 32'(100 + k);
        end
    end

    assign sens_busy   = m_busy | busy_force;
    assign sens_finish = m_fin | fin_inj;

    // Event log sampled mid-cycle, read by the test tasks.
    int          cyc = 0;
    int          req_ch_log[$];
    int          req_cyc_log[$];
    int          res_ch_log[$];
    int          res_cyc_log[$];
    logic [31:0] res_data_log[$];
    int          fin_cyc_log[$];
    int          rdone_n    = 0;
    int          onehot_err = 0;
    int          wide_err   = 0;
    int          coinc_err  = 0;
    int          active_n   = 0;
    logic [NCH-1:0] prev_req = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if ($countones(sens_req) > 1) onehot_err++;
        if ((sens_req & prev_req) != '0) wide_err++;
        if (sens_req != '0) begin
            for (int k = 0; k < NCH; k++) begin
                if (sens_req[k] === 1'b1) req_ch_log.push_back(k);
            end
            req_cyc_log.push_back(cyc);
        end
        prev_req = sens_req;
        if (m_fin != '0) fin_cyc_log.push_back(cyc);
        if (res_valid === 1'b1) begin
            res_ch_log.push_back(int'(res_ch));
            res_data_log.push_back(res_data);
            res_cyc_log.push_back(cyc);
        end
        if (round_done === 1'b1) rdone_n++;
        if ((round_done === 1'b1) && (res_valid === 1'b1)) coinc_err++;
        if (active === 1'b1) active_n++;
    end

    task automatic wait_rdone(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rdone_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ch_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; scan_en = 1'b0; trig = 1'b0; ch_mask = '0; rd_sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++; if (sens_req !== 4'b0) begin bad++; $display("FAIL reset_req: got %b want 0000", sens_req); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        total++; if (res_ch !== 4'd0) begin bad++; $display("FAIL reset_res_ch: got %0d want 0", res_ch); end
        total++; if (res_data !== 32'd0) begin bad++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        total++; if (round_done !== 1'b0) begin bad++; $display("FAIL reset_round_done: got %b want 0", round_done); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
`ifdef SONIC_SCHED_TIMEOUT_EN
        total++; if (err_flags !== 4'b0) begin bad++; $display("FAIL reset_err_flags: got %b want 0000", err_flags); end
`endif
    endtask

    task automatic test_single_round();
        int n0 = res_ch_log.size();
        int r0 = rdone_n;
        bit ok;
        ch_mask = 4'b1111;
        pulse_trig();
        wait_rdone(r0 + 1, 2000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL round_timeout: got no round_done want one"); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL round_active: got %b want 0", active); end
        total++; if (res_ch_log.size() - n0 !== 4) begin bad++; $display("FAIL round_count: got %0d want 4", res_ch_log.size() - n0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (res_ch_log[n0+i] !== i) begin bad++; $display("FAIL round_ch%0d: got %0d want %0d", i, res_ch_log[n0+i], i); end
            total++; if (res_data_log[n0+i] !== 32'(100 + i)) begin bad++; $display("FAIL round_data%0d: got %0d want %0d", i, res_data_log[n0+i], 100 + i); end
        end
        repeat (20) @(negedge clk);
        total++; if (rdone_n - r0 !== 1) begin bad++; $display("FAIL round_done_cnt: got %0d want 1", rdone_n - r0); end
        rd_sel = 4'd2;
        @(negedge clk);
        total++; if (rd_data !== 32'd102) begin bad++; $display("FAIL rd_table2: got %0d want 102", rd_data); end
        rd_sel = 4'd7;
        @(negedge clk);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rd_out_of_range: got %0d want 0", rd_data); end
    endtask

    task automatic test_scan_alternate();
        int n0 = res_ch_log.size();
        int q0 = req_ch_log.size();
        int r0 = rdone_n;
        int min_gap = 1000000;
        bit ok;
        ch_mask = 4'b1010;
        scan_en = 1'b1;
        wait_rdone(r0 + 3, 3000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL scan_3rounds: got %0d rounds want 3", rdone_n - r0); end
        scan_en = 1'b0;
        // The round already started at the wrap completes before going idle.
        wait_rdone(r0 + 4, 1000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL scan_finish_round: got %0d rounds want 4", rdone_n - r0); end
        repeat (5) @(negedge clk);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL scan_idle: got active %b want 0", active); end
        total++; if (res_ch_log.size() - n0 !== 8) begin bad++; $display("FAIL scan_res_count: got %0d want 8", res_ch_log.size() - n0); end
        total++; if (req_ch_log.size() - q0 !== 8) begin bad++; $display("FAIL scan_req_count: got %0d want 8", req_ch_log.size() - q0); end
        for (int i = 0; i < 8; i++) begin
            total++; if (req_ch_log[q0+i] !== ((i % 2) ? 3 : 1)) begin bad++; $display("FAIL scan_req_ch%0d: got %0d want %0d", i, req_ch_log[q0+i], (i % 2) ? 3 : 1); end
            total++; if (res_data_log[n0+i] !== ((i % 2) ? 32'd103 : 32'd101)) begin bad++; $display("FAIL scan_res_data%0d: got %0d want %0d", i, res_data_log[n0+i], (i % 2) ? 103 : 101); end
        end
        for (int j = q0 + 1; j < req_cyc_log.size(); j++) begin
            int last_fin = -1;
            foreach (fin_cyc_log[f]) if (fin_cyc_log[f] < req_cyc_log[j]) last_fin = fin_cyc_log[f];
            if (last_fin >= 0 && (req_cyc_log[j] - last_fin) < min_gap) min_gap = req_cyc_log[j] - last_fin;
        end
        total++; if (!(min_gap >= GAP + 2)) begin bad++; $display("FAIL scan_min_gap: got %0d want >= %0d", min_gap, GAP + 2); end
        total++; if (onehot_err !== 0) begin bad++; $display("FAIL req_onehot: got %0d violations want 0", onehot_err); end
        total++; if (wide_err !== 0) begin bad++; $display("FAIL req_width: got %0d violations want 0", wide_err); end
        total++; if (coinc_err !== 0) begin bad++; $display("FAIL done_vs_valid: got %0d overlaps want 0", coinc_err); end
    endtask

    task automatic test_zero_mask();
        int n0 = res_ch_log.size();
        int q0 = req_ch_log.size();
        int r0 = rdone_n;
        int a0 = active_n;
        ch_mask = 4'b0000;
        scan_en = 1'b1;
        pulse_trig();
        repeat (20) @(negedge clk);
        scan_en = 1'b0;
        total++; if (req_ch_log.size() - q0 !== 0) begin bad++; $display("FAIL zero_req: got %0d want 0", req_ch_log.size() - q0); end
        total++; if (res_ch_log.size() - n0 !== 0) begin bad++; $display("FAIL zero_res: got %0d want 0", res_ch_log.size() - n0); end
        total++; if (rdone_n - r0 !== 0) begin bad++; $display("FAIL zero_round_done: got %0d want 0", rdone_n - r0); end
        total++; if (active_n - a0 !== 0) begin bad++; $display("FAIL zero_active: got %0d cycles want 0", active_n - a0); end
    endtask

    task automatic test_busy_hold();
        int n0 = res_ch_log.size();
        int q0 = req_ch_log.size();
        int r0 = rdone_n;
        int rel_cyc;
        bit ok;
        ch_mask    = 4'b0010;
        busy_force = 4'b0010;
        pulse_trig();
        repeat (10) @(negedge clk);
        fin_inj = 4'b0100;
        @(negedge clk);
        fin_inj = 4'b0000;
        repeat (19) @(negedge clk);
        total++; if (req_ch_log.size() - q0 !== 0) begin bad++; $display("FAIL busy_req_early: got %0d reqs want 0", req_ch_log.size() - q0); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL busy_active: got %b want 1", active); end
        busy_force = 4'b0000;
        rel_cyc = cyc;
        wait_req(q0 + 1, 20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL busy_req_missing: got no req want one"); end
        total++; if (req_ch_log[q0] !== 1) begin bad++; $display("FAIL busy_req_ch: got %0d want 1", req_ch_log[q0]); end
        total++; if (!(req_cyc_log[q0] > rel_cyc)) begin bad++; $display("FAIL busy_req_time: got cycle %0d want > %0d", req_cyc_log[q0], rel_cyc); end
        repeat (10) @(negedge clk);
        fin_inj = 4'b0100;
        @(negedge clk);
        fin_inj = 4'b0000;
        wait_rdone(r0 + 1, 500, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL busy_round: got no round_done want one"); end
        total++; if (res_ch_log.size() - n0 !== 1) begin bad++; $display("FAIL busy_res_count: got %0d want 1", res_ch_log.size() - n0); end
        total++; if (res_ch_log[n0] !== 1) begin bad++; $display("FAIL busy_res_ch: got %0d want 1", res_ch_log[n0]); end
        total++; if (res_data_log[n0] !== 32'd101) begin bad++; $display("FAIL busy_res_data: got %0d want 101", res_data_log[n0]); end
        total++; if (!(res_cyc_log[n0] - req_cyc_log[q0] >= 45)) begin bad++; $display("FAIL busy_foreign_finish: got latency %0d want >= 45", res_cyc_log[n0] - req_cyc_log[q0]); end
    endtask

    task automatic test_reset_mid_shot();
        int n0;
        int q0 = req_ch_log.size();
        bit ok;
        ch_mask = 4'b0100;
        pulse_trig();
        wait_req(q0 + 1, 20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_req: got no req want one"); end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n0 = res_ch_log.size();
        total++; if (sens_req !== 4'b0) begin bad++; $display("FAIL rstmid_req_drop: got %b want 0000", sens_req); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rstmid_active: got %b want 0", active); end
        total++; if (res_ch !== 4'd0) begin bad++; $display("FAIL rstmid_res_ch: got %0d want 0", res_ch); end
        total++; if (res_data !== 32'd0) begin bad++; $display("FAIL rstmid_res_data: got %0d want 0", res_data); end
        rd_sel = 4'd1;
        @(negedge clk);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rstmid_table1: got %0d want 0", rd_data); end
        rd_sel = 4'd3;
        @(negedge clk);
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rstmid_table3: got %0d want 0", rd_data); end
        repeat (60) @(negedge clk);
        total++; if (res_ch_log.size() - n0 !== 0) begin bad++; $display("FAIL rstmid_late_finish: got %0d strobes want 0", res_ch_log.size() - n0); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", active); end
    endtask

`ifdef SONIC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n0 = res_ch_log.size();
        int q0 = req_ch_log.size();
        int r0 = rdone_n;
        bit ok;
        no_fin  = 4'b0001;
        ch_mask = 4'b0011;
        pulse_trig();
        wait_rdone(r0 + 1, 2000, ok);
        no_fin = 4'b0000;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL tmo_round: got no round_done want one"); end
        total++; if (res_ch_log.size() - n0 !== 2) begin bad++; $display("FAIL tmo_res_count: got %0d want 2", res_ch_log.size() - n0); end
        total++; if (res_data_log[n0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmo_ch0_data: got %h want ffffffff", res_data_log[n0]); end
        total++; if (!(res_cyc_log[n0] - req_cyc_log[q0] >= TMO)) begin bad++; $display("FAIL tmo_latency: got %0d want >= %0d", res_cyc_log[n0] - req_cyc_log[q0], TMO); end
        total++; if (res_ch_log[n0+1] !== 1) begin bad++; $display("FAIL tmo_next_ch: got %0d want 1", res_ch_log[n0+1]); end
        total++; if (res_data_log[n0+1] !== 32'd101) begin bad++; $display("FAIL tmo_ch1_data: got %0d want 101", res_data_log[n0+1]); end
        total++; if (err_flags !== 4'b0001) begin bad++; $display("FAIL tmo_err_flags: got %b want 0001", err_flags); end
        rd_sel = 4'd0;
        @(negedge clk);
        total++; if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmo_table0: got %h want ffffffff", rd_data); end
    endtask
`endif

    initial begin
        rst = 1'b1; scan_en = 1'b0; trig = 1'b0; ch_mask = '0; rd_sel = '0;
        test_reset();
        test_single_round();
        test_scan_alternate();
        test_zero_mask();
        test_busy_hold();
        test_reset_mid_shot();
`ifdef SONIC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
